// File: rtl/reg_dest_sequencer_pkg.sv
// Shared CPU package for the write-back destination sequencer.
// Holds the FSM state encoding, the wb_kind request codes, the destination-mux
// (ent_end) and write-data (mem_to_reg) select codes, the fixed register
// numbers for $ra and $sp, and small helpers that map a request kind onto
// those selects.
package reg_dest_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_WRITE    = 2'd2,
        ST_SP_WRITE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        KIND_RTYPE = 2'b00,
        KIND_ITYPE = 2'b01,
        KIND_LOAD  = 2'b10,
        KIND_JAL   = 2'b11
    } wb_kind_t;

    localparam logic [1:0] ENT_RT  = 2'b00;
    localparam logic [1:0] ENT_RD  = 2'b01;
    localparam logic [1:0] ENT_RA  = 2'b10;
    localparam logic [1:0] ENT_SP  = 2'b11;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;
    localparam logic [1:0] MTR_SP  = 2'b11;

    localparam logic [4:0] REG_RA  = 5'd31;
    localparam logic [4:0] REG_SP  = 5'd29;

    function automatic logic [1:0] kind_ent_end(input logic [1:0] kind);
        case (kind)
            KIND_RTYPE: return ENT_RD;
            KIND_JAL:   return ENT_RA;
            default:    return ENT_RT;
        endcase
    endfunction

    function automatic logic [1:0] kind_mem_to_reg(input logic [1:0] kind);
        case (kind)
            KIND_LOAD: return MTR_MEM;
            KIND_JAL:  return MTR_PC4;
            default:   return MTR_ALU;
        endcase
    endfunction

    // Register number the destination mux will select; exported for hazard logic.
    function automatic logic [4:0] kind_dest(input logic [1:0] kind,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd);
        case (kind)
            KIND_RTYPE: return rd;
            KIND_JAL:   return REG_RA;
            default:    return rt;
        endcase
    endfunction

endpackage

// File: rtl/reg_dest_sequencer_wait_counter.sv
// Memory-latency down-counter.
// Ports: clk, reset (async, active-high), load/load_val preset the count,
// dec decrements it (saturating at zero), zero flags terminal count.
module wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/reg_dest_sequencer.sv
// Write-back destination sequencer.
// Turns one-cycle write-back requests from the control unit into a single
// register-bank write with the right destination-mux and write-data selects,
// inserting the memory wait for loads and slotting stack-pointer updates in
// right after the current write.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   wb_req, wb_kind     write-back request and its kind (sampled in IDLE only)
//   sp_req              stack-pointer update request (sampled every cycle)
//   rt, rd              instruction register fields captured with wb_req
//   ent_end, mem_to_reg destination-mux and write-data selects
//   reg_write           register-bank write enable
//   dest_reg            resolved destination register number
//   wb_busy, wb_done    busy level and post-write completion pulse
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | waiting for wb_req or sp_req
// ST_MEM_WAIT | load issued, counting down memory latency
// ST_WRITE    | reg_write for the captured wb request
// ST_SP_WRITE | reg_write of the stack pointer into $29
module reg_dest_sequencer
    import reg_dest_sequencer_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [1:0] wb_kind,
    input  logic       sp_req,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    output logic [1:0] ent_end,
    output logic [1:0] mem_to_reg,
    output logic       reg_write,
    output logic [4:0] dest_reg,
    output logic       wb_busy,
    output logic       wb_done
);

    // The MEM_WAIT state lasts MEM_WAIT cycles: the cycle that reaches zero is
    // the last one before WRITE.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t     state, next_state;
    logic [1:0] kind_q, kind_d;
    logic [4:0] rt_q, rt_d, rd_q, rd_d;
    logic       sp_pending, sp_pending_d, sp_eff;
    logic       cnt_load, cnt_dec, cnt_zero;

    logic [1:0] ent_end_d, mem_to_reg_d;
    logic [4:0] dest_reg_d;
    logic       reg_write_d, wb_busy_d, wb_done_d;

    wait_counter #(.WIDTH(4)) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // An sp_req arriving this cycle counts as pending so it is never lost,
    // even when it coincides with the decision to leave a write state.
    assign sp_eff = sp_pending | sp_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            kind_q     <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            sp_pending <= 1'b0;
            ent_end    <= '0;
            mem_to_reg <= '0;
            dest_reg   <= '0;
            reg_write  <= 1'b0;
            wb_busy    <= 1'b0;
            wb_done    <= 1'b0;
        end else begin
            state      <= next_state;
            kind_q     <= kind_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            sp_pending <= sp_pending_d;
            ent_end    <= ent_end_d;
            mem_to_reg <= mem_to_reg_d;
            dest_reg   <= dest_reg_d;
            reg_write  <= reg_write_d;
            wb_busy    <= wb_busy_d;
            wb_done    <= wb_done_d;
        end
    end

    always_comb begin
        next_state = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (wb_req) begin
                    if (wb_kind == KIND_LOAD) begin
                        next_state = ST_MEM_WAIT;
                        cnt_load   = 1'b1;
                    end else begin
                        next_state = ST_WRITE;
                    end
                end else if (sp_eff) begin
                    next_state = ST_SP_WRITE;
                end
            end
            ST_MEM_WAIT: begin
                if (cnt_zero) next_state = ST_WRITE;
                else          cnt_dec    = 1'b1;
            end
            ST_WRITE, ST_SP_WRITE: begin
                next_state = sp_eff ? ST_SP_WRITE : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Request fields are taken straight from the inputs on the capture cycle so
    // a non-load request can be written on the very next cycle.
    always_comb begin
        kind_d = kind_q;
        rt_d   = rt_q;
        rd_d   = rd_q;
        if ((state == ST_IDLE) && wb_req) begin
            kind_d = wb_kind;
            rt_d   = rt;
            rd_d   = rd;
        end
        sp_pending_d = (next_state == ST_SP_WRITE) ? 1'b0 : sp_eff;
    end

    // Outputs are computed for the state being entered and registered, so they
    // line up with the state and stay glitch-free. Selects hold between writes.
    always_comb begin
        reg_write_d  = 1'b0;
        ent_end_d    = ent_end;
        mem_to_reg_d = mem_to_reg;
        dest_reg_d   = dest_reg;
        wb_busy_d    = (next_state != ST_IDLE);
        wb_done_d    = (state == ST_WRITE);
        case (next_state)
            ST_WRITE: begin
                reg_write_d  = 1'b1;
                ent_end_d    = kind_ent_end(kind_d);
                mem_to_reg_d = kind_mem_to_reg(kind_d);
                dest_reg_d   = kind_dest(kind_d, rt_d, rd_d);
            end
            ST_SP_WRITE: begin
                reg_write_d  = 1'b1;
                ent_end_d    = ENT_SP;
                mem_to_reg_d = MTR_SP;
                dest_reg_d   = REG_SP;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_dest_sequencer.sv
module tb_reg_dest_sequencer;

    localparam int MW = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wb_req = 1'b0;
    logic [1:0] wb_kind = 2'b00;
    logic       sp_req = 1'b0;
    logic [4:0] rt = 5'd0;
    logic [4:0] rd = 5'd0;
    logic [1:0] ent_end, mem_to_reg;
    logic       reg_write;
    logic [4:0] dest_reg;
    logic       wb_busy, wb_done;

    reg_dest_sequencer #(.MEM_WAIT(MW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_req     (wb_req),
        .wb_kind    (wb_kind),
        .sp_req     (sp_req),
        .rt         (rt),
        .rd         (rd),
        .ent_end    (ent_end),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .dest_reg   (dest_reg),
        .wb_busy    (wb_busy),
        .wb_done    (wb_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [1:0] ent;
        logic [1:0] mtr;
        logic [4:0] dest;
    } wr_t;

    wr_t        exp_q[$];
    int         done_q[$];
    bit         busy_map[int];
    bit         mon_en = 1'b0;
    logic [1:0] last_ent = 2'b00;
    logic [1:0] last_mtr = 2'b00;
    logic [4:0] last_dest = 5'd0;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: what a write of each request kind looks like on the bus.
    function automatic wr_t kind_write(input logic [1:0] k, input logic [4:0] t,
                                       input logic [4:0] d, input int at);
        wr_t w;
        w.at = at;
        case (k)
            2'b00:   begin w.ent = 2'b01; w.mtr = 2'b00; w.dest = d;     end
            2'b01:   begin w.ent = 2'b00; w.mtr = 2'b00; w.dest = t;     end
            2'b10:   begin w.ent = 2'b00; w.mtr = 2'b01; w.dest = t;     end
            default: begin w.ent = 2'b10; w.mtr = 2'b10; w.dest = 5'd31; end
        endcase
        return w;
    endfunction

    // Monitor: compares every cycle against the expectations queued by the driver.
    always @(negedge clk) begin
        if (mon_en) begin
            wr_t e;
            check("wb_busy", wb_busy, busy_map.exists(cyc));
            if (reg_write) begin
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("write_cycle", cyc, e.at);
                    check("ent_end", ent_end, e.ent);
                    check("mem_to_reg", mem_to_reg, e.mtr);
                    check("dest_reg", dest_reg, e.dest);
                    last_ent  = e.ent;
                    last_mtr  = e.mtr;
                    last_dest = e.dest;
                end
            end else begin
                check("hold_ent_end", ent_end, last_ent);
                check("hold_mem_to_reg", mem_to_reg, last_mtr);
                check("hold_dest_reg", dest_reg, last_dest);
                if (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
                    check("write_missed", cyc, exp_q[0].at);
                    void'(exp_q.pop_front());
                end
            end
            if (wb_done) begin
                check("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) check("done_cycle", cyc, done_q.pop_front());
            end else if (done_q.size() != 0 && done_q[0] <= cyc) begin
                check("done_missed", cyc, done_q[0]);
                void'(done_q.pop_front());
            end
        end
    end

    // One wb request. sp_mode: 0 none, 1 random, 2 every wait cycle.
    task automatic do_txn(input logic [1:0] k, input logic [4:0] t, input logic [4:0] d,
                          input bit sp0, input int sp_mode, input bit busyreq);
        int c, w, last_c;
        bit sp_any;
        bit spb[$];
        @(negedge clk);
        c = cyc;
        wb_req = 1'b1; wb_kind = k; rt = t; rd = d; sp_req = sp0;
        w = c + ((k == 2'b10) ? MW + 1 : 1);
        sp_any = sp0;
        for (int n = c + 1; n < w; n++) begin
            bit b;
            b = (sp_mode == 2) || (sp_mode == 1 && $urandom_range(0, 2) == 0);
            spb.push_back(b);
            sp_any |= b;
        end
        exp_q.push_back(kind_write(k, t, d, w));
        done_q.push_back(w + 1);
        if (sp_any) exp_q.push_back('{w + 1, 2'b11, 2'b11, 5'd29});
        last_c = sp_any ? w + 1 : w;
        for (int n = c + 1; n <= last_c; n++) busy_map[n] = 1'b1;
        for (int n = c + 1; n <= last_c; n++) begin
            @(negedge clk);
            sp_req  = (n < w) ? spb[n - c - 1] : 1'b0;
            wb_req  = busyreq && (n == c + 1 || $urandom_range(0, 1) == 1);
            wb_kind = 2'($urandom_range(0, 3));
            rt      = 5'($urandom_range(0, 31));
            rd      = 5'($urandom_range(0, 31));
        end
        wb_req = 1'b0;
        sp_req = 1'b0;
    endtask

    task automatic sp_txn();
        int c;
        @(negedge clk);
        c = cyc;
        sp_req = 1'b1;
        exp_q.push_back('{c + 1, 2'b11, 2'b11, 5'd29});
        busy_map[c + 1] = 1'b1;
        @(negedge clk);
        sp_req = 1'b0;
    endtask

    initial begin
        int rw_seen;
        #1 reset = 1'b1;
        #1;
        check("rst_reg_write", reg_write, 0);
        check("rst_ent_end", ent_end, 0);
        check("rst_mem_to_reg", mem_to_reg, 0);
        check("rst_dest_reg", dest_reg, 0);
        check("rst_wb_busy", wb_busy, 0);
        check("rst_wb_done", wb_done, 0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        do_txn(2'b00, 5'd3, 5'd8, 1'b0, 0, 1'b0);
        do_txn(2'b10, 5'd5, 5'd17, 1'b0, 0, 1'b0);
        do_txn(2'b11, 5'd1, 5'd2, 1'b1, 0, 1'b0);
        do_txn(2'b10, 5'd9, 5'd4, 1'b0, 2, 1'b0);
        do_txn(2'b10, 5'd7, 5'd6, 1'b0, 0, 1'b1);
        do_txn(2'b01, 5'd12, 5'd13, 1'b0, 1, 1'b1);
        sp_txn();

        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 5) == 0) sp_txn();
            else do_txn(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                        5'($urandom_range(0, 31)), $urandom_range(0, 3) == 0,
                        $urandom_range(0, 1), $urandom_range(0, 3) == 0);
        end
        repeat (4) @(negedge clk);

        // Reset in the middle of a load wait.
        @(negedge clk);
        mon_en = 1'b0;
        wb_req = 1'b1; wb_kind = 2'b10; rt = 5'd5; rd = 5'd0;
        @(negedge clk);
        wb_req = 1'b0;
        check("busy_before_reset", wb_busy, 1);
        #1 reset = 1'b1;
        #1;
        check("arst_reg_write", reg_write, 0);
        check("arst_wb_busy", wb_busy, 0);
        check("arst_ent_end", ent_end, 0);
        check("arst_mem_to_reg", mem_to_reg, 0);
        check("arst_dest_reg", dest_reg, 0);
        check("arst_wb_done", wb_done, 0);
        @(negedge clk);
        reset     = 1'b0;
        last_ent  = 2'b00;
        last_mtr  = 2'b00;
        last_dest = 5'd0;
        mon_en    = 1'b1;
        rw_seen   = 0;
        repeat (6) begin
            @(negedge clk);
            #1 rw_seen += int'(reg_write);
        end
        check("writes_after_reset", rw_seen, 0);

        do_txn(2'b01, 5'd21, 5'd22, 1'b1, 0, 1'b0);
        repeat (4) @(negedge clk);
        check("writes_outstanding", exp_q.size(), 0);
        check("dones_outstanding", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
